// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
// Iterative multiply / divide unit that owns the HI/LO register pair.
// Multiply is a one-bit-per-cycle shift-add over a double-width accumulator,
// divide is a restoring shift-subtract. Signed operations run on magnitudes
// and are sign-corrected in a single FIXUP cycle before HI/LO are written.
module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_1,
   input  logic [WIDTH-1:0] src_2,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CALC  = 2'b01,
      ST_FIXUP = 2'b10
   } state_e;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic is_muldiv(input logic [2:0] o);
      return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

   function automatic logic is_div_op(input logic [2:0] o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   // ------------------------------------------------------------------
   // State and working registers
   // ------------------------------------------------------------------
   state_e               state_q,   state_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [2:0]           op_q,      op_d;
   logic [WIDTH-1:0]     a_raw_q,   a_raw_d;    // dividend as given, for divide-by-zero HI
   logic [WIDTH-1:0]     opb_q,     opb_d;      // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0]   acc_q,     acc_d;      // product, or quotient in the low half
   logic [WIDTH-1:0]     rem_q,     rem_d;      // settled partial remainder (< divisor)
   logic                 neg_res_q, neg_res_d;  // operand signs differ
   logic                 neg_rem_q, neg_rem_d;  // dividend was negative
   logic                 bzero_q,   bzero_d;    // divisor was zero
   logic                 busy_q,    busy_d;
   logic                 done_q,    done_d;
   logic                 dz_q,      dz_d;
   logic [WIDTH-1:0]     hi_q,      hi_d;
   logic [WIDTH-1:0]     lo_q,      lo_d;

   logic                 accept_s;
   logic                 a_neg_s, b_neg_s;
   logic [WIDTH-1:0]     a_mag_s, b_mag_s;
   logic [WIDTH:0]       mul_sum_s;
   logic [WIDTH:0]       div_shift_s;
   logic [WIDTH:0]       div_diff_s;
   logic                 div_ge_s;
   logic [2*WIDTH-1:0]   prod_fix_s;
   logic [WIDTH-1:0]     quo_fix_s;
   logic [WIDTH-1:0]     rem_fix_s;

   // abort in IDLE suppresses any same-cycle request
   assign accept_s = (state_q == ST_IDLE) && start && !abort;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE -> CALC for WIDTH cycles -> FIXUP -> IDLE, abort returns to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && is_muldiv(op)) begin
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_FIXUP;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_FIXUP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Operand conditioning, single iteration step and final sign correction
   always_comb begin
      a_neg_s     = is_signed_op(op) & src_1[WIDTH-1];
      b_neg_s     = is_signed_op(op) & src_2[WIDTH-1];
      a_mag_s     = a_neg_s ? neg_w(src_1) : src_1;
      b_mag_s     = b_neg_s ? neg_w(src_2) : src_2;

      if (acc_q[0]) begin
         mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
      end else begin
         mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      end

      div_shift_s = {rem_q, acc_q[WIDTH-1]};
      div_diff_s  = div_shift_s - {1'b0, opb_q};
      div_ge_s    = (div_shift_s >= {1'b0, opb_q});

      prod_fix_s  = neg_res_q ? neg_2w(acc_q) : acc_q;
      quo_fix_s   = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      rem_fix_s   = neg_rem_q ? neg_w(rem_q) : rem_q;
   end

   // Output and datapath next-state logic (outputs follow the state machine)
   always_comb begin
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_raw_d   = a_raw_q;
      opb_d     = opb_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      bzero_d   = bzero_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      busy_d    = (state_d != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               case (op)
                  OP_MTHI: begin
                     hi_d = src_1;
                  end
                  OP_MTLO: begin
                     lo_d = src_1;
                  end
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     op_d      = op;
                     cnt_d     = CNT_ZERO;
                     a_raw_d   = src_1;
                     neg_res_d = a_neg_s ^ b_neg_s;
                     neg_rem_d = a_neg_s;
                     bzero_d   = (src_2 == {WIDTH{1'b0}});
                     dz_d      = 1'b0;
                     rem_d     = {WIDTH{1'b0}};
                     if (is_div_op(op)) begin
                        opb_d = b_mag_s;
                        acc_d = {{WIDTH{1'b0}}, a_mag_s};
                     end else begin
                        opb_d = a_mag_s;
                        acc_d = {{WIDTH{1'b0}}, b_mag_s};
                     end
                  end
                  default: begin
                     hi_d = hi_q;
                  end
               endcase
            end else begin
               hi_d = hi_q;
            end
         end
         ST_CALC: begin
            if (!abort) begin
               cnt_d = cnt_q + CNT_ONE;
               if (is_div_op(op_q)) begin
                  if (div_ge_s) begin
                     rem_d = div_diff_s[WIDTH-1:0];
                  end else begin
                     rem_d = div_shift_s[WIDTH-1:0];
                  end
                  acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge_s};
               end else begin
                  acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_FIXUP: begin
            if (!abort) begin
               done_d = 1'b1;
               if (is_div_op(op_q)) begin
                  dz_d = bzero_q;
                  if (bzero_q) begin
                     hi_d = a_raw_q;
                     lo_d = {WIDTH{1'b1}};
                  end else begin
                     hi_d = rem_fix_s;
                     lo_d = quo_fix_s;
                  end
               end else begin
                  hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix_s[WIDTH-1:0];
               end
            end else begin
               done_d = 1'b0;
            end
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= CNT_ZERO;
         op_q      <= 3'b000;
         a_raw_q   <= {WIDTH{1'b0}};
         opb_q     <= {WIDTH{1'b0}};
         acc_q     <= {(2*WIDTH){1'b0}};
         rem_q     <= {WIDTH{1'b0}};
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         bzero_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
      end else begin
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         a_raw_q   <= a_raw_d;
         opb_q     <= opb_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         bzero_q   <= bzero_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed vector table, multi-cycle
// corner sequences and randomized operations against an arithmetic model.
module tb_mips_muldiv_unit;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_1;
   logic [31:0] src_2;
   logic        abort;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;

   mips_muldiv_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .op       (op),
      .src_1    (src_1),
      .src_2    (src_2),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic
   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el, output logic edz);
      longint sa, sb, p, q, r;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      edz = 1'b0;
      eh = 32'h0;
      el = 32'h0;
      case (o)
         OP_MULT: begin
            p = sa * sb;
            eh = p[63:32];
            el = p[31:0];
         end
         OP_MULTU: begin
            up = {32'h0, a} * {32'h0, b};
            eh = up[63:32];
            el = up[31:0];
         end
         OP_DIV, OP_DIVU: begin
            if (b == 32'h0) begin
               eh = a;
               el = 32'hFFFF_FFFF;
               edz = 1'b1;
            end else if (o == OP_DIV) begin
               q = sa / sb;
               r = sa % sb;
               eh = r[31:0];
               el = q[31:0];
            end else begin
               eh = a % b;
               el = a / b;
            end
         end
         default: begin
            eh = 32'h0;
         end
      endcase
   endfunction

   // Issue a mult/div at the current negedge and follow it to done.
   // inj > 0 pulses a competing MULT start in that busy cycle.
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int inj,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz);
      int cyc;
      int nbusy;
      logic got;
      start = 1'b1; op = o; src_1 = a; src_2 = b;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; nbusy = 0; got = 1'b0;
      while (cyc < 60) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (busy) nbusy++;
         if (cyc == inj) begin
            start = 1'b1; op = OP_MULT; src_1 = 32'd7; src_2 = 32'd9;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({name, " done_seen"}, {63'h0, got}, 64'h1);
      check({name, " done_cycle"}, 64'(cyc), 64'd34);
      check({name, " busy_cycles"}, 64'(nbusy), 64'd33);
      check({name, " hi"}, {32'h0, hi}, {32'h0, eh});
      check({name, " lo"}, {32'h0, lo}, {32'h0, el});
      check({name, " div_zero"}, {63'h0, div_zero}, {63'h0, edz});
   endtask

   // Start an op, abort it in busy cycle k, and confirm nothing completes.
   task automatic abort_op(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input int k,
                           input logic [31:0] ph, input logic [31:0] pl);
      int ndone;
      start = 1'b1; op = o; src_1 = a; src_2 = b;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < k; c++) @(negedge clk);
      check({name, " busy_before"}, {63'h0, busy}, 64'h1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check({name, " busy_after"}, {63'h0, busy}, 64'h0);
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check({name, " no_done"}, 64'(ndone), 64'd0);
      check({name, " hi_hold"}, {32'h0, hi}, {32'h0, ph});
      check({name, " lo_hold"}, {32'h0, lo}, {32'h0, pl});
   endtask

   vec_t vecs[6];
   logic [31:0] eh, el, ra, rb;
   logic        edz;
   logic [2:0]  ro;
   int          ndone;

   initial begin
      vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
      vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0};
      vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      vecs[4] = '{OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
      vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};

      reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = 3'b000; src_1 = 32'h0; src_2 = 32'h0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("reset hi", {32'h0, hi}, 64'h0);
      check("reset lo", {32'h0, lo}, 64'h0);
      check("reset busy", {63'h0, busy}, 64'h0);
      check("reset done", {63'h0, done}, 64'h0);
      check("reset div_zero", {63'h0, div_zero}, 64'h0);

      // Directed vectors; done must be a single-cycle pulse
      for (int i = 0; i < 6; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0,
                vecs[i].hi, vecs[i].lo, vecs[i].dz);
         @(negedge clk);
         check($sformatf("vec%0d done_pulse", i), {63'h0, done}, 64'h0);
      end

      // MTHI / MTLO take effect at the accept edge without busy
      start = 1'b1; op = OP_MTHI; src_1 = 32'hA5A5_A5A5;
      @(negedge clk);
      check("mthi hi", {32'h0, hi}, 64'hA5A5_A5A5);
      check("mthi busy", {63'h0, busy}, 64'h0);
      op = OP_MTLO; src_1 = 32'h5A5A_5A5A;
      @(negedge clk);
      start = 1'b0;
      check("mtlo lo", {32'h0, lo}, 64'h5A5A_5A5A);
      check("mtlo hi", {32'h0, hi}, 64'hA5A5_A5A5);
      check("mtlo busy", {63'h0, busy}, 64'h0);
      check("mtlo done", {63'h0, done}, 64'h0);

      // Undefined op is ignored
      start = 1'b1; op = 3'b111; src_1 = 32'h1111_1111;
      @(negedge clk);
      start = 1'b0;
      check("undef busy", {63'h0, busy}, 64'h0);
      check("undef hi", {32'h0, hi}, 64'hA5A5_A5A5);

      // Competing start during a running DIV is ignored
      model(OP_DIV, 32'hFFFF_FF00, 32'h10, eh, el, edz);
      run_op("div_inject", OP_DIV, 32'hFFFF_FF00, 32'h10, 10, eh, el, edz);
      @(negedge clk);
      check("div_inject idle", {63'h0, busy}, 64'h0);

      // Abort mid-CALC and in FIXUP
      abort_op("abort_calc", OP_MULT, 32'd1234, 32'd5678, 20, eh, el);
      abort_op("abort_fixup", OP_DIVU, 32'd99, 32'd3, 33, eh, el);

      // Abort in IDLE blocks a same-cycle start
      start = 1'b1; abort = 1'b1; op = OP_MULT; src_1 = 32'd3; src_2 = 32'd3;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("abort_idle busy", {63'h0, busy}, 64'h0);
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("abort_idle no_done", 64'(ndone), 64'd0);
      check("abort_idle lo", {32'h0, lo}, {32'h0, el});

      // Randomized operations against the model
      for (int i = 0; i < 30; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'h0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         model(ro, ra, rb, eh, el, edz);
         run_op($sformatf("rnd%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb, 0, eh, el, edz);
      end
      @(negedge clk);

      // Back-to-back: second op starts in the done cycle
      run_op("b2b_mult", OP_MULT, 32'd3, 32'd5, 0, 32'd0, 32'd15, 1'b0);
      run_op("b2b_divu", OP_DIVU, 32'd15, 32'd4, 0, 32'd3, 32'd3, 1'b0);
      @(negedge clk);

      // Asynchronous reset between edges during a DIV
      start = 1'b1; op = OP_DIV; src_1 = 32'd1000; src_2 = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst hi", {32'h0, hi}, 64'h0);
      check("async_rst lo", {32'h0, lo}, 64'h0);
      check("async_rst busy", {63'h0, busy}, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         if (done || busy) ndone++;
         @(negedge clk);
      end
      check("async_rst quiet", 64'(ndone), 64'd0);
      check("async_rst lo_after", {32'h0, lo}, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound, got running expected finished");
      $fatal(1);
   end

endmodule
